// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared types and helpers for the GEMM tile scheduler.
package gemm_tile_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } sched_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gemm_tile_scheduler_tile_counter.sv
// Nested k/t/w index counter: advance_k steps (and wraps) the K-chunk,
// advance_tile steps the tensor tile and carries into the weight tile.
module gemm_tile_scheduler_tile_counter #(
  parameter int T_W = 12,
  parameter int W_W = 8,
  parameter int K_W = 12
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           clear,
  input  logic           advance_k,
  input  logic           advance_tile,
  input  logic [T_W-1:0] cfg_t,
  input  logic [W_W-1:0] cfg_w,
  input  logic [K_W-1:0] cfg_k,
  output logic [T_W-1:0] t_idx,
  output logic [W_W-1:0] w_idx,
  output logic [K_W-1:0] k_idx,
  output logic           last_t,
  output logic           last_w,
  output logic           last_k
);

  assign last_t = (t_idx == cfg_t);
  assign last_w = (w_idx == cfg_w);
  assign last_k = (k_idx == cfg_k);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_idx <= '0;
      w_idx <= '0;
      k_idx <= '0;
    end else if (clear) begin
      t_idx <= '0;
      w_idx <= '0;
      k_idx <= '0;
    end else begin
      if (advance_k)
        k_idx <= last_k ? '0 : k_idx + 1'b1;
      // wrap on equality with the configured maximum, never on overflow
      if (advance_tile) begin
        if (last_t) begin
          t_idx <= '0;
          w_idx <= last_w ? '0 : w_idx + 1'b1;
        end else begin
          t_idx <= t_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// img2col GEMM sequencer: weight tiles (outer), tensor tiles, K-chunks (inner),
// with an S2P*S2P accumulator drain per output tile. Perf counters under GEMM_SCHED_PERF_EN.
module gemm_tile_scheduler
  import gemm_tile_scheduler_pkg::*;
#(
  parameter int S2P = 8,
  parameter int T_W = 12,
  parameter int W_W = 8,
  parameter int K_W = 12
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic [T_W-1:0] cfg_t_tiles,
  input  logic [W_W-1:0] cfg_w_tiles,
  input  logic [K_W-1:0] cfg_k_chunks,
  output logic           ld_valid,
  input  logic           ld_ready,
  output logic [T_W-1:0] ld_t_idx,
  output logic [W_W-1:0] ld_w_idx,
  output logic [K_W-1:0] ld_k_idx,
  output logic           ld_first,
  input  logic           mul_done,
  output logic           tensor_done,
  output logic           weight_done,
  output logic           busy,
  output logic           done,
  output logic [31:0]    perf_cycles,
  output logic [31:0]    perf_stalls
);

  localparam int DRAIN_N = S2P * S2P;
  localparam int DC_W    = $clog2(DRAIN_N) + 1;

  sched_state_e   state;
  logic [T_W-1:0] cfg_t_q;
  logic [W_W-1:0] cfg_w_q;
  logic [K_W-1:0] cfg_k_q;
  logic [DC_W-1:0] drain_cnt;
  logic last_t, last_w, last_k;

  wire start_acc = (state == ST_IDLE) && start;
  wire adv_k     = (state == ST_WAIT) && mul_done;
  wire drain_end = (drain_cnt == DC_W'(DRAIN_N - 1));
  wire adv_tile  = (state == ST_DRAIN) && drain_end;

  gemm_tile_scheduler_tile_counter #(.T_W(T_W), .W_W(W_W), .K_W(K_W)) u_cnt (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (start_acc),
    .advance_k    (adv_k),
    .advance_tile (adv_tile),
    .cfg_t        (cfg_t_q),
    .cfg_w        (cfg_w_q),
    .cfg_k        (cfg_k_q),
    .t_idx        (ld_t_idx),
    .w_idx        (ld_w_idx),
    .k_idx        (ld_k_idx),
    .last_t       (last_t),
    .last_w       (last_w),
    .last_k       (last_k)
  );

  // gated by ld_valid so the output idles at 0 out of reset
  assign ld_first = ld_valid && (ld_k_idx == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cfg_t_q     <= '0;
      cfg_w_q     <= '0;
      cfg_k_q     <= '0;
      drain_cnt   <= '0;
      ld_valid    <= 1'b0;
      tensor_done <= 1'b0;
      weight_done <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tensor_done <= 1'b0;
      weight_done <= 1'b0;
      done        <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          cfg_t_q <= cfg_t_tiles;
          cfg_w_q <= cfg_w_tiles;
          cfg_k_q <= cfg_k_chunks;
          busy    <= 1'b1;
          state   <= ST_ISSUE;
        end
        // one bubble cycle before ld_valid rises, then hold until accepted
        ST_ISSUE: begin
          if (!ld_valid) begin
            ld_valid <= 1'b1;
          end else if (ld_ready) begin
            ld_valid    <= 1'b0;
            tensor_done <= (ld_k_idx == '0) && last_t;
            weight_done <= (ld_k_idx == '0) && last_t && last_w;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: if (mul_done) begin
          drain_cnt <= '0;
          state     <= last_k ? ST_DRAIN : ST_ISSUE;
        end
        ST_DRAIN: begin
          if (drain_end)
            state <= (last_t && last_w) ? ST_FIN : ST_ISSUE;
          else
            drain_cnt <= drain_cnt + 1'b1;
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GEMM_SCHED_PERF_EN
  logic [31:0] pc_q, ps_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= '0;
      ps_q <= '0;
    end else if (start_acc) begin
      pc_q <= '0;
      ps_q <= '0;
    end else begin
      if (busy)                  pc_q <= sat_inc32(pc_q);
      if (ld_valid && !ld_ready) ps_q <= sat_inc32(ps_q);
    end
  end

  assign perf_cycles = pc_q;
  assign perf_stalls = ps_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Self-checking bench for gemm_tile_scheduler: a request-list model drives
// expected valid/index/pulse/done timing per cycle.
module tb_gemm_tile_scheduler;

  localparam int DRAIN = 64;
  localparam int NONE  = 1 << 30;

  typedef struct {int t; int w; int k;} req_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [11:0] cfg_t_tiles;
  logic [7:0]  cfg_w_tiles;
  logic [11:0] cfg_k_chunks;
  logic        ld_valid, ld_ready;
  logic [11:0] ld_t_idx;
  logic [7:0]  ld_w_idx;
  logic [11:0] ld_k_idx;
  logic        ld_first, mul_done, tensor_done, weight_done, busy, done;
  logic [31:0] perf_cycles, perf_stalls;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  gemm_tile_scheduler dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_t_tiles(cfg_t_tiles), .cfg_w_tiles(cfg_w_tiles), .cfg_k_chunks(cfg_k_chunks),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_t_idx(ld_t_idx), .ld_w_idx(ld_w_idx), .ld_k_idx(ld_k_idx), .ld_first(ld_first),
    .mul_done(mul_done), .tensor_done(tensor_done), .weight_done(weight_done),
    .busy(busy), .done(done), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, ld_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_tdone"}, tensor_done, 0);
    chk({tag, "_wdone"}, weight_done, 0);
    chk({tag, "_first"}, ld_first, 0);
    chk({tag, "_idx"},   {ld_t_idx, ld_w_idx, ld_k_idx[11:0]}, 0);
    chk({tag, "_pcyc"},  perf_cycles, 0);
    chk({tag, "_pstl"},  perf_stalls, 0);
  endtask

  // One convolution. Model: ordered request list; valid rises 2 cycles after
  // start or a mid-tile mul_done, DRAIN+2 after a tile-final mul_done.
  task automatic run_conv(input int ct, input int cw, input int ck, input bit rnd,
                          input int stall_n, input bit spur, input int abort_at,
                          input bit extra_start);
    req_t q[$];
    req_t r;
    int c, vrise, md_cyc, done_cyc, drain_from, nacc, acc_cyc, stalls, stall_left, k_fly;
    bit vnow, exp_td, exp_wd;
    for (int w = 0; w <= cw; w++)
      for (int t = 0; t <= ct; t++)
        for (int k = 0; k <= ck; k++) begin
          r.t = t; r.w = w; r.k = k;
          q.push_back(r);
        end
    c = 0; vrise = 2; md_cyc = NONE; done_cyc = NONE; drain_from = NONE;
    nacc = 0; acc_cyc = NONE; stalls = 0; stall_left = stall_n; k_fly = 0;
    exp_td = 0; exp_wd = 0;
    @(negedge clk);
    cfg_t_tiles = 12'(ct); cfg_w_tiles = 8'(cw); cfg_k_chunks = 12'(ck);
    start = 1'b1; ld_ready = 1'b0; mul_done = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      start = 1'b0; mul_done = 1'b0;
      vnow = (c >= vrise);
      chk("busy", busy, c < done_cyc);
      chk("ld_valid", ld_valid, vnow);
      chk("done", done, c == done_cyc);
      chk("tensor_done", tensor_done, exp_td);
      chk("weight_done", weight_done, exp_wd);
      exp_td = 0; exp_wd = 0;
      if (vnow) begin
        chk("ld_t_idx", ld_t_idx, q[0].t);
        chk("ld_w_idx", ld_w_idx, q[0].w);
        chk("ld_k_idx", ld_k_idx, q[0].k);
        chk("ld_first", ld_first, q[0].k == 0);
      end
      if (abort_at != 0 && nacc == abort_at && c == acc_cyc + 1) begin
        rstn = 1'b0; ld_ready = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      if (vnow && nacc == 1 && stall_left > 0) begin
        ld_ready = 1'b0;
        stall_left--;
      end else begin
        ld_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (vnow && !ld_ready) stalls++;
      if (c == md_cyc) begin
        mul_done = 1'b1; md_cyc = NONE;
        if (k_fly < ck) vrise = c + 2;
        else if (q.size() == 0) begin done_cyc = c + DRAIN + 2; drain_from = c; end
        else begin vrise = c + DRAIN + 2; drain_from = c; end
      end else if (spur && ((vrise != NONE && c == vrise - 1) || (vnow && !ld_ready) ||
                            (drain_from != NONE && c == drain_from + 10))) begin
        mul_done = 1'b1;
      end
      if (vnow && ld_ready) begin
        r = q.pop_front();
        nacc++; acc_cyc = c; k_fly = r.k;
        exp_td = (r.k == 0) && (r.t == ct);
        exp_wd = exp_td && (r.w == cw);
        md_cyc = c + (rnd ? int'($urandom_range(1, 5)) : 3);
        vrise = NONE;
      end
      if (extra_start && (c == 6 || c == done_cyc - 1)) start = 1'b1;
      if (done_cyc != NONE && c >= done_cyc + 3) break;
      if (c > 20000) begin
        chk("timeout", 0, 1);
        break;
      end
    end
`ifdef GEMM_SCHED_PERF_EN
    chk("perf_cycles", perf_cycles, done_cyc - 1);
    chk("perf_stalls", perf_stalls, stalls);
`else
    chk("perf_cycles", perf_cycles, 0);
    chk("perf_stalls", perf_stalls, 0);
`endif
    ld_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; ld_ready = 1'b0; mul_done = 1'b0;
    cfg_t_tiles = '0; cfg_w_tiles = '0; cfg_k_chunks = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    run_conv(0, 0, 0, 0, 0, 0, 0, 0);   // single tile
    run_conv(2, 0, 2, 0, 0, 0, 0, 0);   // 9 requests, k order
    run_conv(1, 0, 1, 0, 5, 0, 0, 0);   // 5-cycle stall on 2nd request
    run_conv(1, 1, 1, 1, 0, 1, 0, 0);   // spurious mul_done in ISSUE/DRAIN
    run_conv(1, 1, 2, 0, 0, 0, 4, 0);   // reset during WAIT of 4th request
    run_conv(1, 1, 2, 0, 0, 0, 0, 0);   // clean rerun
    run_conv(1, 0, 0, 0, 0, 0, 0, 1);   // start while busy and at FIN
    repeat (4)
      run_conv(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), 1, 0, bit'($urandom_range(0, 1)), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
